// File: rtl/day10_pkg.sv
// Shared types, default widths and the popcount width helper for the day10
// solver and the result accumulator.
package day10_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } acc_state_e;

    localparam int DEF_MAX_NUM_BUTTONS = 13;
    localparam int DEF_TOTAL_W         = 32;
    localparam int DEF_MACHINE_CNT_W   = 16;

    // Bits needed to hold a count of 0..n set buttons.
    function automatic int popcount_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n + 1);
        end
    endfunction

endpackage

// File: rtl/day10_output_if.sv
// Per-machine result bundle from the day10 solver: claimed minimum press count
// and the button mask that achieves it.
interface day10_output_if
    import day10_pkg::*;
#(
    parameter int MAX_NUM_BUTTONS   = DEF_MAX_NUM_BUTTONS,
    parameter int MAX_NUM_PRESSES_W = popcount_w(MAX_NUM_BUTTONS)
);
    logic [MAX_NUM_PRESSES_W-1:0] min_button_presses;
    logic [MAX_NUM_BUTTONS-1:0]   buttons_to_press;

    modport producer (output min_button_presses, output buttons_to_press);
    modport consumer (input  min_button_presses, input  buttons_to_press);
endinterface

// File: rtl/day10_serial_popcount.sv
// Bit-serial popcount: load a mask, then shift one bit per cycle into the
// counter. done flags that the current shift empties the mask.
module day10_serial_popcount
    import day10_pkg::*;
#(
    parameter int MAX_NUM_BUTTONS   = DEF_MAX_NUM_BUTTONS,
    parameter int MAX_NUM_BUTTONS_W = popcount_w(MAX_NUM_BUTTONS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         load,
    input  logic [MAX_NUM_BUTTONS-1:0]   load_mask,
    input  logic                         shift,
    output logic                         done,
    output logic [MAX_NUM_BUTTONS_W-1:0] count
);

    logic [MAX_NUM_BUTTONS-1:0]   mask_r;
    logic [MAX_NUM_BUTTONS-1:0]   mask_shift_s;
    logic [MAX_NUM_BUTTONS_W-1:0] count_r;

    assign mask_shift_s = mask_r >> 1;
    // Early exit looks at the post-shift mask so the FSM leaves SCAN on the last useful bit.
    assign done  = (mask_shift_s == '0);
    assign count = count_r;

    // Mask shifter and ones counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r  <= '0;
            count_r <= '0;
        end else if (clear) begin
            mask_r  <= '0;
            count_r <= '0;
        end else if (load) begin
            mask_r  <= load_mask;
            count_r <= '0;
        end else if (shift) begin
            mask_r  <= mask_shift_s;
            count_r <= count_r + MAX_NUM_BUTTONS_W'(mask_r[0]);
        end else begin
            mask_r  <= mask_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/day10_result_accumulator.sv
// Consumes day10 per-machine results, re-verifies each mask popcount against
// the claimed press count and accumulates the saturating puzzle total.
module day10_result_accumulator
    import day10_pkg::*;
#(
    parameter int MAX_NUM_BUTTONS   = DEF_MAX_NUM_BUTTONS,
    parameter int MAX_NUM_BUTTONS_W = popcount_w(MAX_NUM_BUTTONS),
    parameter int MAX_NUM_PRESSES_W = MAX_NUM_BUTTONS_W,
    parameter int TOTAL_W           = DEF_TOTAL_W,
    parameter int MACHINE_CNT_W     = DEF_MACHINE_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    day10_output_if.consumer         res,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic                     clear,
    output logic [TOTAL_W-1:0]       total,
    output logic                     total_valid,
    output logic [MACHINE_CNT_W-1:0] machine_count,
    output logic                     mismatch,
    output logic [MACHINE_CNT_W-1:0] first_bad_index,
    output logic                     overflow
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SCAN  = SCAN;
    localparam logic [1:0] ST_CHECK = CHECK;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]                   state_r;
    logic [1:0]                   state_nxt_s;
    logic                         in_ready_r;
    logic [TOTAL_W-1:0]           total_r;
    logic                         total_valid_r;
    logic [MACHINE_CNT_W-1:0]     machine_count_r;
    logic                         mismatch_r;
    logic [MACHINE_CNT_W-1:0]     first_bad_index_r;
    logic                         overflow_r;
    logic [MAX_NUM_PRESSES_W-1:0] presses_r;
    logic                         last_r;

    logic                         pc_load_s;
    logic                         pc_shift_s;
    logic                         pc_done_s;
    logic [MAX_NUM_BUTTONS_W-1:0] pc_count_s;
    logic [TOTAL_W:0]             presses_ext_s;
    logic [TOTAL_W:0]             count_ext_s;
    logic [TOTAL_W:0]             sum_s;
    logic                         bad_s;

    day10_serial_popcount #(
        .MAX_NUM_BUTTONS   (MAX_NUM_BUTTONS),
        .MAX_NUM_BUTTONS_W (MAX_NUM_BUTTONS_W)
    ) u_popcount (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .load      (pc_load_s),
        .load_mask (res.buttons_to_press),
        .shift     (pc_shift_s),
        .done      (pc_done_s),
        .count     (pc_count_s)
    );

    assign presses_ext_s = {{(TOTAL_W + 1 - MAX_NUM_PRESSES_W){1'b0}}, presses_r};
    assign count_ext_s   = {{(TOTAL_W + 1 - MAX_NUM_BUTTONS_W){1'b0}}, pc_count_s};
    // The extra top bit of the sum is the carry that triggers saturation.
    assign sum_s         = {1'b0, total_r} + presses_ext_s;
    assign bad_s         = (count_ext_s != presses_ext_s);

    // Next-state decode and popcount control.
    always_comb begin
        state_nxt_s = state_r;
        pc_load_s   = 1'b0;
        pc_shift_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    pc_load_s   = 1'b1;
                    state_nxt_s = (res.buttons_to_press != '0) ? ST_SCAN : ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                pc_shift_s = 1'b1;
                if (pc_done_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_CHECK: begin
                state_nxt_s = last_r ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, handshake, accumulators and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= ST_IDLE;
            in_ready_r        <= 1'b1;
            total_r           <= '0;
            total_valid_r     <= 1'b0;
            machine_count_r   <= '0;
            mismatch_r        <= 1'b0;
            first_bad_index_r <= '0;
            overflow_r        <= 1'b0;
            presses_r         <= '0;
            last_r            <= 1'b0;
        end else if (clear) begin
            state_r           <= ST_IDLE;
            in_ready_r        <= 1'b1;
            total_r           <= '0;
            total_valid_r     <= 1'b0;
            machine_count_r   <= '0;
            mismatch_r        <= 1'b0;
            first_bad_index_r <= '0;
            overflow_r        <= 1'b0;
            presses_r         <= '0;
            last_r            <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            // Ready reopens one cycle after returning to IDLE, drops on the accepting edge.
            in_ready_r    <= (state_r == ST_IDLE) && (state_nxt_s == ST_IDLE);
            total_valid_r <= (state_r == ST_DONE);
            if (pc_load_s) begin
                presses_r <= res.min_button_presses;
                last_r    <= in_last;
            end
            if (state_r == ST_CHECK) begin
                if (bad_s && !mismatch_r) begin
                    mismatch_r        <= 1'b1;
                    first_bad_index_r <= machine_count_r;
                end
                if (sum_s[TOTAL_W]) begin
                    total_r    <= '1;
                    overflow_r <= 1'b1;
                end else begin
                    total_r <= sum_s[TOTAL_W-1:0];
                end
                machine_count_r <= machine_count_r + MACHINE_CNT_W'(1);
            end
        end
    end

    assign in_ready        = in_ready_r;
    assign total           = total_r;
    assign total_valid     = total_valid_r;
    assign machine_count   = machine_count_r;
    assign mismatch        = mismatch_r;
    assign first_bad_index = first_bad_index_r;
    assign overflow        = overflow_r;

endmodule

// File: tb/tb_day10_result_accumulator.sv
// Directed, table-driven bench for day10_result_accumulator plus a TOTAL_W=4
// instance for saturation.
module tb_day10_result_accumulator;
    import day10_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_last, clear;
    logic        in_ready, total_valid, mismatch, overflow;
    logic [31:0] total;
    logic [15:0] machine_count, first_bad_index;

    logic        in_valid2, in_last2;
    logic        in_ready2, total_valid2, mismatch2, overflow2;
    logic [3:0]  total2;
    logic [15:0] machine_count2, first_bad_index2;

    int n_tests = 0;
    int n_fail  = 0;

    day10_output_if #(.MAX_NUM_BUTTONS(13)) res_if ();
    day10_output_if #(.MAX_NUM_BUTTONS(13)) res_if2 ();

    day10_result_accumulator dut (
        .clk(clk), .rst_n(rst_n), .res(res_if), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .clear(clear), .total(total), .total_valid(total_valid),
        .machine_count(machine_count), .mismatch(mismatch),
        .first_bad_index(first_bad_index), .overflow(overflow)
    );

    day10_result_accumulator #(.TOTAL_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .res(res_if2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_last(in_last2), .clear(1'b0), .total(total2), .total_valid(total_valid2),
        .machine_count(machine_count2), .mismatch(mismatch2),
        .first_bad_index(first_bad_index2), .overflow(overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        clr;
        logic [3:0]  p;
        logic [12:0] m;
        logic        l;
        int          low;
        int          tot;
        int          cnt;
        logic        mm;
        int          fbi;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Wait for ready, transfer one result, return cycles spent with in_ready low.
    task automatic send1(input logic [3:0] p, input logic [12:0] m, input logic l, output int low);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_xfer", {31'd0, in_ready}, 32'd1);
        res_if.min_button_presses = p;
        res_if.buttons_to_press   = m;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        low = 0;
        while (!in_ready && !total_valid && low < 50) begin
            low++;
            @(negedge clk);
        end
    endtask

    initial begin
        int low;
        int xfers;
        int dbl;
        logic [15:0] prev_cnt;

        vecs[0]  = '{1'b0, 4'd2,  13'b0000000001010, 1'b0, 6,  2,  1, 1'b0, 0};
        vecs[1]  = '{1'b0, 4'd3,  13'b0000000001101, 1'b0, 6,  5,  2, 1'b0, 0};
        vecs[2]  = '{1'b0, 4'd2,  13'b0000000000110, 1'b1, 5,  7,  3, 1'b0, 0};
        vecs[3]  = '{1'b1, 4'd3,  13'b0000000000011, 1'b0, 4,  3,  1, 1'b1, 0};
        vecs[4]  = '{1'b0, 4'd1,  13'b0000000000001, 1'b0, 3,  4,  2, 1'b1, 0};
        vecs[5]  = '{1'b0, 4'd2,  13'b0000000000100, 1'b1, 5,  6,  3, 1'b1, 0};
        vecs[6]  = '{1'b1, 4'd0,  13'b0000000000000, 1'b1, 2,  0,  1, 1'b0, 0};
        vecs[7]  = '{1'b1, 4'd1,  13'b0000000000001, 1'b0, 3,  1,  1, 1'b0, 0};
        vecs[8]  = '{1'b0, 4'd2,  13'b0000000000101, 1'b0, 5,  3,  2, 1'b0, 0};
        vecs[9]  = '{1'b0, 4'd3,  13'b0000000000001, 1'b0, 3,  6,  3, 1'b1, 2};
        vecs[10] = '{1'b0, 4'd1,  13'b1000000000000, 1'b0, 15, 7,  4, 1'b1, 2};
        vecs[11] = '{1'b0, 4'd1,  13'b0000000001111, 1'b1, 6,  8,  5, 1'b1, 2};
        vecs[12] = '{1'b1, 4'd13, 13'b1111111111111, 1'b1, 15, 13, 1, 1'b0, 0};

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
        in_valid2 = 1'b0; in_last2 = 1'b0;
        res_if.min_button_presses  = 4'd0; res_if.buttons_to_press  = 13'd0;
        res_if2.min_button_presses = 4'd0; res_if2.buttons_to_press = 13'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_total", total, 32'd0);
        chk("rst_total_valid", {31'd0, total_valid}, 32'd0);
        chk("rst_count", {16'd0, machine_count}, 32'd0);
        chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].clr) begin
                pulse_clear();
                chk($sformatf("v%0d_clr_total", i), total, 32'd0);
                chk($sformatf("v%0d_clr_count", i), {16'd0, machine_count}, 32'd0);
                chk($sformatf("v%0d_clr_ready", i), {31'd0, in_ready}, 32'd1);
                chk($sformatf("v%0d_clr_tvalid", i), {31'd0, total_valid}, 32'd0);
            end
            send1(vecs[i].p, vecs[i].m, vecs[i].l, low);
            chk($sformatf("v%0d_low_cycles", i), low, vecs[i].low);
            chk($sformatf("v%0d_total", i), total, vecs[i].tot);
            chk($sformatf("v%0d_count", i), {16'd0, machine_count}, vecs[i].cnt);
            chk($sformatf("v%0d_mismatch", i), {31'd0, mismatch}, {31'd0, vecs[i].mm});
            chk($sformatf("v%0d_first_bad", i), {16'd0, first_bad_index}, vecs[i].fbi);
            chk($sformatf("v%0d_total_valid", i), {31'd0, total_valid}, {31'd0, vecs[i].l});
        end

        // Backpressure: in_valid held high, new data presented each ready window.
        pulse_clear();
        xfers = 0; dbl = 0; prev_cnt = machine_count;
        in_valid = 1'b1;
        for (int c = 0; c < 120 && !total_valid; c++) begin
            if (in_ready) begin
                res_if.min_button_presses = 4'd1;
                res_if.buttons_to_press   = 13'd1 << xfers;
                in_last = (xfers == 3);
                xfers++;
            end
            @(negedge clk);
            if (machine_count != prev_cnt && machine_count != prev_cnt + 16'd1) dbl++;
            prev_cnt = machine_count;
        end
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("bp_windows", xfers, 32'd4);
        chk("bp_count", {16'd0, machine_count}, 32'd4);
        chk("bp_total", total, 32'd4);
        chk("bp_double_count", dbl, 32'd0);
        chk("bp_total_valid", {31'd0, total_valid}, 32'd1);

        // Clear during SCAN of the second result.
        pulse_clear();
        send1(4'd2, 13'b0000000001010, 1'b0, low);
        res_if.min_button_presses = 4'd3;
        res_if.buttons_to_press   = 13'b0000000001101;
        in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        pulse_clear();
        chk("midscan_clr_total", total, 32'd0);
        chk("midscan_clr_count", {16'd0, machine_count}, 32'd0);
        chk("midscan_clr_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk("midscan_discarded", {16'd0, machine_count}, 32'd0);
        send1(4'd2, 13'b0000000000001, 1'b1, low);
        chk("after_clr_count", {16'd0, machine_count}, 32'd1);
        chk("after_clr_total", total, 32'd2);
        chk("after_clr_mismatch", {31'd0, mismatch}, 32'd1);
        chk("after_clr_first_bad", {16'd0, first_bad_index}, 32'd0);

        // clear wins over a simultaneous transfer.
        pulse_clear();
        res_if.min_button_presses = 4'd1;
        res_if.buttons_to_press   = 13'd1;
        in_last = 1'b1; in_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_override_count", {16'd0, machine_count}, 32'd0);
        chk("clr_override_ready", {31'd0, in_ready}, 32'd1);
        chk("clr_override_tvalid", {31'd0, total_valid}, 32'd0);

        // Asynchronous reset in the middle of a long SCAN.
        send1(4'd1, 13'd1, 1'b0, low);
        chk("prerst_total", total, 32'd1);
        res_if.min_button_presses = 4'd1;
        res_if.buttons_to_press   = 13'b1000000000000;
        in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_total", total, 32'd0);
        chk("async_rst_count", {16'd0, machine_count}, 32'd0);
        chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Saturation on the TOTAL_W=4 instance: 4+4+4+4+4 clamps at 15.
        for (int i = 0; i < 5; i++) begin
            int guard;
            guard = 0;
            while (!in_ready2 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            res_if2.min_button_presses = 4'd4;
            res_if2.buttons_to_press   = 13'b0000000001111;
            in_last2 = (i == 4); in_valid2 = 1'b1;
            @(negedge clk);
            in_valid2 = 1'b0;
            guard = 0;
            while (!in_ready2 && !total_valid2 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (i == 2) begin
                chk("sat_total_at_3", {28'd0, total2}, 32'd12);
                chk("sat_overflow_at_3", {31'd0, overflow2}, 32'd0);
            end
            if (i == 3) begin
                chk("sat_total_at_4", {28'd0, total2}, 32'd15);
                chk("sat_overflow_at_4", {31'd0, overflow2}, 32'd1);
            end
        end
        chk("sat_total", {28'd0, total2}, 32'd15);
        chk("sat_overflow", {31'd0, overflow2}, 32'd1);
        chk("sat_count", {16'd0, machine_count2}, 32'd5);
        chk("sat_total_valid", {31'd0, total_valid2}, 32'd1);
        chk("sat_mismatch", {31'd0, mismatch2}, 32'd0);
        chk("sat_first_bad", {16'd0, first_bad_index2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
